// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - sequencer states, immediate formats, RV32I opcodes and branch funct3 codes
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK
  } seq_state_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Opcodes whose retirement writes the destination register.
  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default:                      writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_imm_gen.sv
// rtl/pc_imm_gen.sv - combinational I/S/B/U/J immediate decode, sign-extended to XLEN
module pc_imm_gen
  import pc_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     ir_bits,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] imm
);

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = {{(XLEN-11){ir_bits[31]}}, ir_bits[30:20]};
  assign imm_s = {{(XLEN-11){ir_bits[31]}}, ir_bits[30:25], ir_bits[11:7]};
  assign imm_b = {{(XLEN-12){ir_bits[31]}}, ir_bits[7], ir_bits[30:25], ir_bits[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){ir_bits[31]}}, ir_bits[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){ir_bits[31]}}, ir_bits[19:12], ir_bits[20], ir_bits[30:21], 1'b0};

  // Pick the format requested by the opcode decode in the sequencer.
  always_comb begin
    imm = imm_i;
    case (imm_sel)
      IMM_S:   imm = imm_s;
      IMM_B:   imm = imm_b;
      IMM_U:   imm = imm_u;
      IMM_J:   imm = imm_j;
      default: imm = imm_i;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle PC sequencer; define PC_SEQ_MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VECTOR
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] curr_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            reg_we,
  output logic [XLEN-1:0] link_addr,
  output logic            pc_update,
  output logic [XLEN-1:0] next_addr,
  output logic            misalign_trap
);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_MASK    = XLEN'(1);

  seq_state_t      state;
  seq_state_t      state_nxt;
  logic [31:0]     ir;
  logic            trap_q;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [2:0]      imm_sel;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            is_store;
  logic            is_mem;

  assign opcode        = ir[6:0];
  assign funct3        = ir[14:12];
  assign is_store      = (opcode == OPC_STORE);
  assign is_mem        = is_store || (opcode == OPC_LOAD);
  assign link_addr     = curr_addr + INSTR_BYTES;
  // trap_q only ever sets when the redirect feature is compiled in
  assign misalign_trap = pc_update & trap_q;

  // Immediate format is chosen by the opcode held in IR.
  always_comb begin
    imm_sel = IMM_I;
    case (opcode)
      OPC_STORE:          imm_sel = IMM_S;
      OPC_BRANCH:         imm_sel = IMM_B;
      OPC_LUI, OPC_AUIPC: imm_sel = IMM_U;
      OPC_JAL:            imm_sel = IMM_J;
      default:            imm_sel = IMM_I;
    endcase
  end

  pc_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .ir_bits (ir[31:7]),
    .imm_sel (imm_sel),
    .imm     (imm)
  );

  // Control-flow target and taken decision, used during EXECUTE.
  always_comb begin
    taken  = 1'b0;
    target = curr_addr + imm;
    case (opcode)
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:  taken = (rs1_data == rs2_data);
          F3_BNE:  taken = (rs1_data != rs2_data);
          F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
          F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
          F3_BLTU: taken = (rs1_data <  rs2_data);
          F3_BGEU: taken = (rs1_data >= rs2_data);
          default: taken = 1'b0;
        endcase
      end
      OPC_JAL: taken = 1'b1;
      OPC_JALR: begin
        taken  = 1'b1;
        target = (rs1_data + imm) & ~LSB_MASK;
      end
      default: taken = 1'b0;
    endcase
  end

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/strobe outputs, all decoded from the current state.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    pc_update = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE:  state_nxt = ST_EXECUTE;
      ST_EXECUTE: state_nxt = is_mem ? ST_MEMORY : ST_WRITEBACK;
      ST_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            // stores have nothing to write back and retire on the ack cycle
            pc_update = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        pc_update = 1'b1;
        reg_we    = writes_rd(opcode) & ~trap_q;
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // IR capture, sequential next PC and misaligned-redirect flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir        <= '0;
      next_addr <= '0;
      trap_q    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            ir <= imem_rdata;
          end
        end
        ST_DECODE: begin
          next_addr <= curr_addr + INSTR_BYTES;
          trap_q    <= 1'b0;
        end
        ST_EXECUTE: begin
          if (taken) begin
            if (TRAP_EN && target[1]) begin
              next_addr <= TRAP_VECTOR;
              trap_q    <= 1'b1;
            end else begin
              next_addr <= target;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer that drives the program counter register: it issues the instruction fetch, decodes control flow, and produces `next_addr` plus a one-cycle `pc_update` strobe once per retired instruction. It consumes `curr_addr` from the PC register and sits between the PC register, instruction/data memory handshakes and the register file write port of the multi-cycle core.

## Interface
- `XLEN`, 32: address/data width.
- `TRAP_VECTOR`, 32'h0000_0100: redirect address on misaligned target (only with `PC_SEQ_MISALIGN_TRAP_EN`).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `curr_addr` in XLEN: current PC from the PC register.
- `imem_req` out 1: fetch request, high throughout FETCH.
- `imem_ack` in 1: fetch complete; `imem_rdata` valid in same cycle.
- `imem_rdata` in 32: fetched instruction.
- `rs1_data`, `rs2_data` in XLEN: register file read data, valid from EXECUTE onward.
- `dmem_req` out 1: data access request, high throughout MEMORY.
- `dmem_we` out 1: 1 = store, 0 = load; valid while `dmem_req`.
- `dmem_ack` in 1: data access complete.
- `reg_we` out 1: register file write enable, one cycle in WRITEBACK.
- `link_addr` out XLEN: `curr_addr + 4`, write-back value for JAL/JALR.
- `pc_update` out 1: one-cycle strobe; PC register loads `next_addr` at that edge.
- `next_addr` out XLEN: registered next PC.
- `misalign_trap` out 1: pulses with `pc_update` on redirected misaligned target.

## Operation
- States: INIT, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- INIT -> FETCH unconditionally. FETCH holds `imem_req` until `imem_ack`; instruction latched into IR on that edge -> DECODE.
- DECODE: `next_addr <= curr_addr + 4`; immediate decoded from IR -> EXECUTE.
- EXECUTE: target computed; `next_addr` overwritten if taken. LOAD/STORE -> MEMORY; all others -> WRITEBACK.
- Targets: BRANCH `curr_addr + immB`; JAL `curr_addr + immJ`; JALR `(rs1_data + immI) & ~1`.
- Branch compare by funct3: BEQ, BNE, BLT/BGE signed, BLTU/BGEU unsigned; funct3 010/011 = not taken.
- MEMORY holds `dmem_req` until `dmem_ack`; load -> WRITEBACK; store retires on the ack cycle (`pc_update` high then) -> FETCH.
- WRITEBACK: `pc_update` = 1; `reg_we` = 1 for LOAD, OP, OP-IMM, LUI, AUIPC, JAL, JALR; 0 for BRANCH/unknown -> FETCH.
- Unknown opcode: no-op, retires with `next_addr = curr_addr + 4`.
- All address arithmetic is modulo 2^XLEN; wrap from 32'hFFFF_FFFC to 0 is legal.

## Timing
- Reset (async): state INIT; `pc_update`, `imem_req`, `dmem_req`, `dmem_we`, `reg_we`, `misalign_trap` = 0; `next_addr` = 0; IR = 0. Rst mid-instruction aborts it; no `pc_update` is issued for it.
- `imem_req` first high in the 2nd cycle after rst deasserts.
- Zero-wait latency, FETCH to `pc_update`: ALU/branch/jump 4 cycles, store 4, load 5; each wait cycle on ack adds one.
- `pc_update` is exactly one cycle per instruction; `next_addr` is stable from end of EXECUTE through `pc_update` and held until next DECODE.
- FETCH following `pc_update` sees the updated `curr_addr`.
- Ack while its req is low is ignored.

## Configuration
- `PC_SEQ_MISALIGN_TRAP_EN` defined: taken target with bit 1 set -> `next_addr = TRAP_VECTOR`, `misalign_trap` = 1 with `pc_update`, `reg_we` suppressed for that instruction.
- Undefined: target used unchanged; `misalign_trap` tied 0.

## Structure
- Package `pc_seq_pkg`: state enum, RV32I opcode constants, branch funct3 constants.
- Sub-module `pc_imm_gen`: combinational I/S/B/U/J immediate decode from IR.

## Test plan
- Reset: rst=1 during EXECUTE -> `pc_update`=0, `next_addr`=0 immediately; after release `imem_req`=1 in 2nd cycle.
- ADDI at `curr_addr`=0x4444, immediate acks -> `pc_update` on 4th cycle, `next_addr`=0x4448, `reg_we`=1.
- BEQ rs1=rs2=5, immB=+16 at 0x100 -> `next_addr`=0x110; BNE same operands -> 0x104, `reg_we`=0.
- JALR rs1=0x2001, immI=4 at 0x100 -> `next_addr`=0x2004, `link_addr`=0x104, `reg_we`=1.
- LW with `dmem_ack` delayed 3 cycles -> single `pc_update` on 8th cycle, `next_addr`=`curr_addr`+4.
- JAL immJ=+6 at 0x100 -> with macro `next_addr`=0x100, `misalign_trap`=1, `reg_we`=0; without macro `next_addr`=0x106.
